// File: rtl/panda_hazard_controller.sv
// Hazard/stall controller for the 5-stage core: load-use, mul/div occupancy, dmem wait, branch redirect.
// Optional performance counters are enabled with the PANDA_STALL_PERF_EN macro.
module panda_hazard_controller #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_addr_id_i,
  input  logic [4:0] rs2_addr_id_i,
  input  logic       rs1_used_id_i,
  input  logic       rs2_used_id_i,
  input  logic [4:0] rd_addr_ex_i,
  input  logic       mem_read_ex_i,
  input  logic       branch_taken_ex_i,
  input  logic       mul_ex_i,
  input  logic       div_ex_i,
  input  logic       div_done_i,
  input  logic       dmem_stall_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       bubble_ex_o,
  output logic       bubble_mem_o,
  output logic       flush_id_o,
  output logic       div_start_o
`ifdef PANDA_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MC_W-1:0] MUL_LOAD = (MUL_CYCLES > 2) ? MC_W'(MUL_CYCLES - 2) : '0;
  localparam logic MUL_STALLS = (MUL_CYCLES > 1);

  typedef enum logic [1:0] {RUN, MUL_WAIT, DIV_WAIT} state_t;

  state_t          state, state_nxt;
  logic [MC_W-1:0] mul_cnt, mul_cnt_nxt;
  logic            done_pend, done_pend_nxt;
  logic            load_use;
  logic            stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id, div_start;

  assign load_use = mem_read_ex_i && (rd_addr_ex_i != 5'd0) &&
                    ((rs1_used_id_i && (rs1_addr_id_i == rd_addr_ex_i)) ||
                     (rs2_used_id_i && (rs2_addr_id_i == rd_addr_ex_i)));

  always_comb begin
    state_nxt     = state;
    mul_cnt_nxt   = mul_cnt;
    done_pend_nxt = done_pend;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    bubble_ex     = 1'b0;
    bubble_mem    = 1'b0;
    flush_id      = 1'b0;
    div_start     = 1'b0;
    if (dmem_stall_i) begin
      // Whole pipe frozen; a divider completion seen now is remembered for later.
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      if ((state == DIV_WAIT) && div_done_i) done_pend_nxt = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mul_ex_i && MUL_STALLS) begin
            {stall_if, stall_id, stall_ex, bubble_mem} = 4'b1111;
            mul_cnt_nxt = MUL_LOAD;
            state_nxt   = MUL_WAIT;
          end else if (div_ex_i && !mul_ex_i) begin
            div_start = 1'b1;
            if (!div_done_i) begin
              {stall_if, stall_id, stall_ex, bubble_mem} = 4'b1111;
              state_nxt = DIV_WAIT;
            end
          end
          if (!stall_if) begin
            if (branch_taken_ex_i) begin
              flush_id  = 1'b1;
              bubble_ex = 1'b1;
            end else if (load_use) begin
              stall_if  = 1'b1;
              stall_id  = 1'b1;
              bubble_ex = 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          if (mul_cnt != '0) begin
            {stall_if, stall_id, stall_ex, bubble_mem} = 4'b1111;
            mul_cnt_nxt = mul_cnt - MC_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        DIV_WAIT: begin
          if (div_done_i || done_pend) begin
            done_pend_nxt = 1'b0;
            state_nxt     = RUN;
          end else begin
            {stall_if, stall_id, stall_ex, bubble_mem} = 4'b1111;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      mul_cnt   <= '0;
      done_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      mul_cnt   <= mul_cnt_nxt;
      done_pend <= done_pend_nxt;
    end
  end

  assign stall_if_o   = stall_if   & ~rst_i;
  assign stall_id_o   = stall_id   & ~rst_i;
  assign stall_ex_o   = stall_ex   & ~rst_i;
  assign bubble_ex_o  = bubble_ex  & ~rst_i;
  assign bubble_mem_o = bubble_mem & ~rst_i;
  assign flush_id_o   = flush_id   & ~rst_i;
  assign div_start_o  = div_start  & ~rst_i;

`ifdef PANDA_STALL_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_if_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_id_o) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_panda_hazard_controller.sv
// Bench for panda_hazard_controller: vector table, directed multi-cycle sequences and a random run against a reference model.
module tb_panda_hazard_controller;
  localparam int MUL_CYCLES = 3;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic rs1u, rs2u, memrd, br, mul, div, done, dmem;
  logic sif, sid, sex, bex, bmem, fl, dst;
  logic [6:0] act;
`ifdef PANDA_STALL_PERF_EN
  logic [CNT_W-1:0] scnt, fcnt;
  logic [CNT_W-1:0] m_scnt, m_fcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: remaining EX cycles of a multiply, divider wait flag, latched completion.
  int   m_mul_left, n_mul_left;
  bit   m_div_wait, n_div_wait, m_pend, n_pend;
  logic [6:0] exp_v;

  always #5 clk = ~clk;

  panda_hazard_controller #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_addr_id_i(rs1), .rs2_addr_id_i(rs2),
    .rs1_used_id_i(rs1u), .rs2_used_id_i(rs2u),
    .rd_addr_ex_i(rd), .mem_read_ex_i(memrd),
    .branch_taken_ex_i(br), .mul_ex_i(mul), .div_ex_i(div),
    .div_done_i(done), .dmem_stall_i(dmem),
    .stall_if_o(sif), .stall_id_o(sid), .stall_ex_o(sex),
    .bubble_ex_o(bex), .bubble_mem_o(bmem), .flush_id_o(fl),
    .div_start_o(dst)
`ifdef PANDA_STALL_PERF_EN
    , .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
`endif
  );

  assign act = {sif, sid, sex, bex, bmem, fl, dst};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       rs1u, rs2u, memrd, br, mul, div, done, dmem;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check7(input string name, input logic [6:0] a, input logic [6:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got {sif,sid,sex,bex,bmem,flush,dstart}=%b expected %b", name, a, e);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic clr_inputs();
    rs1 = '0; rs2 = '0; rd = '0;
    {rs1u, rs2u, memrd, br, mul, div, done, dmem} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic [6:0] e);
    #1;
    check7(name, act, e);
    tick();
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_mul_left = 0; m_div_wait = 0; m_pend = 0;
`ifdef PANDA_STALL_PERF_EN
    m_scnt = '0; m_fcnt = '0;
`endif
  endtask

  // Expected outputs from the priority rules; bit order {sif,sid,sex,bex,bmem,flush,dstart}.
  task automatic model_eval();
    bit lu;
    exp_v = '0;
    n_mul_left = m_mul_left; n_div_wait = m_div_wait; n_pend = m_pend;
    lu = memrd && (rd != 0) && ((rs1u && rs1 == rd) || (rs2u && rs2 == rd));
    if (dmem) begin
      exp_v = 7'b1110000;
      if (m_div_wait && done) n_pend = 1;
    end else if (m_mul_left > 0) begin
      if (m_mul_left > 1) exp_v = 7'b1110100;
      n_mul_left = m_mul_left - 1;
    end else if (m_div_wait) begin
      if (done || m_pend) begin
        n_div_wait = 0;
        n_pend = 0;
      end else exp_v = 7'b1110100;
    end else begin
      if (mul && MUL_CYCLES > 1) begin
        exp_v = 7'b1110100;
        n_mul_left = MUL_CYCLES - 1;
      end else if (div && !mul) begin
        exp_v[0] = 1'b1;
        if (!done) begin
          exp_v[6:2] = 5'b11101;
          n_div_wait = 1;
        end
      end
      if (!exp_v[6]) begin
        if (br) begin
          exp_v[3] = 1'b1; exp_v[1] = 1'b1;
        end else if (lu) begin
          exp_v[6] = 1'b1; exp_v[5] = 1'b1; exp_v[3] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = '{"lu_rs2",      5'd0, 5'd5, 5'd5, 0,1,1,0,0,0,0,0, 7'b1101000};
    vecs[1]  = '{"lu_rd_x0",    5'd0, 5'd0, 5'd0, 0,1,1,0,0,0,0,0, 7'b0000000};
    vecs[2]  = '{"lu_rs1",      5'd7, 5'd3, 5'd7, 1,1,1,0,0,0,0,0, 7'b1101000};
    vecs[3]  = '{"lu_unused",   5'd7, 5'd3, 5'd7, 0,1,1,0,0,0,0,0, 7'b0000000};
    vecs[4]  = '{"no_load",     5'd7, 5'd7, 5'd7, 1,1,0,0,0,0,0,0, 7'b0000000};
    vecs[5]  = '{"branch",      5'd1, 5'd2, 5'd3, 1,1,0,1,0,0,0,0, 7'b0001010};
    vecs[6]  = '{"branch_lu",   5'd4, 5'd2, 5'd4, 1,1,1,1,0,0,0,0, 7'b0001010};
    vecs[7]  = '{"dmem_br_lu",  5'd4, 5'd2, 5'd4, 1,1,1,1,0,0,0,1, 7'b1110000};
    vecs[8]  = '{"div_done_now",5'd0, 5'd0, 5'd0, 0,0,0,0,0,1,1,0, 7'b0000001};
    vecs[9]  = '{"dmem_div",    5'd0, 5'd0, 5'd0, 0,0,0,0,0,1,0,1, 7'b1110000};
    vecs[10] = '{"idle_after",  5'd0, 5'd0, 5'd0, 0,0,0,0,0,0,0,0, 7'b0000000};

    clr_inputs();
    rst = 1'b1;
    #2;
    check7("reset_outputs", act, 7'b0000000);
    tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
      rs1u = vecs[i].rs1u; rs2u = vecs[i].rs2u; memrd = vecs[i].memrd;
      br = vecs[i].br; mul = vecs[i].mul; div = vecs[i].div;
      done = vecs[i].done; dmem = vecs[i].dmem;
      step(vecs[i].name, vecs[i].exp);
    end

    // Multiply occupies EX for three cycles.
    clr_inputs(); mul = 1;
    step("mul_c1", 7'b1110100);
    step("mul_c2", 7'b1110100);
    step("mul_c3", 7'b0000000);
    mul = 0;
    step("mul_after", 7'b0000000);

    // Divide with completion after six stalled cycles.
    div = 1;
    step("div_c1", 7'b1110101);
    for (int c = 2; c <= 6; c++) step($sformatf("div_c%0d", c), 7'b1110100);
    done = 1;
    step("div_done", 7'b0000000);
    div = 0; done = 0;
    step("div_after", 7'b0000000);

    // Completion arrives under a dmem stall and must be remembered.
    div = 1;
    step("dp_start", 7'b1110101);
    dmem = 1; done = 1;
    step("dp_dmem_done", 7'b1110000);
    done = 0;
    step("dp_dmem_hold", 7'b1110000);
    dmem = 0;
    step("dp_release", 7'b0000000);
    div = 0;
    step("dp_after", 7'b0000000);

    // Asynchronous reset in the middle of a multiply.
    mul = 1;
    step("rm_c1", 7'b1110100);
    #1;
    check7("rm_c2", act, 7'b1110100);
    #2 rst = 1'b1;
    #1;
    check7("rm_reset_now", act, 7'b0000000);
`ifdef PANDA_STALL_PERF_EN
    check_cnt("rm_stall_cnt", scnt, '0);
    check_cnt("rm_flush_cnt", fcnt, '0);
`endif
    tick();
    rst = 1'b0; mul = 0;
    step("rm_after", 7'b0000000);

    // Random run against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      rs1u = 1'($urandom_range(0, 1)); rs2u = 1'($urandom_range(0, 1));
      memrd = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 5) == 0);
      mul  = ($urandom_range(0, 7) == 0);
      div  = ($urandom_range(0, 7) == 0);
      done = ($urandom_range(0, 3) == 0);
      dmem = ($urandom_range(0, 4) == 0);
      #1;
      model_eval();
      check7($sformatf("rand_%0d", n), act, exp_v);
      @(posedge clk);
      m_mul_left = n_mul_left; m_div_wait = n_div_wait; m_pend = n_pend;
`ifdef PANDA_STALL_PERF_EN
      if (exp_v[6]) m_scnt = m_scnt + 1'b1;
      if (exp_v[1]) m_fcnt = m_fcnt + 1'b1;
      #1;
      check_cnt($sformatf("rand_scnt_%0d", n), scnt, m_scnt);
      check_cnt($sformatf("rand_fcnt_%0d", n), fcnt, m_fcnt);
`else
      #1;
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
